// File: rtl/ice_sl_bus_arbiter.sv
// ice_sl_bus_arbiter
//   Round-robin arbiter for the shared slave output bus. One-hot registered
//   grant, optional priority class, and a hold watchdog that revokes a stuck
//   owner and locks it out until it drops its request. Every ownership
//   change passes through a RELEASE turnaround cycle, so the bus always sees
//   at least one all-zero grant cycle between owners.

module ice_sl_bus_arbiter #(
  parameter int               NUM_DEV    = 7,
  parameter int               ID_W       = 3,
  parameter int               TMO_W      = 20,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 20'd1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_DEV-1:0] prio_mask,
  input  logic [NUM_DEV-1:0] sl_arb_request,
  output logic [NUM_DEV-1:0] sl_arb_grant,
  output logic [ID_W-1:0]    owner_id,
  output logic               busy,
  output logic               tmo_pulse,
  output logic [NUM_DEV-1:0] tmo_sticky,
  input  logic               tmo_clear
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [NUM_DEV-1:0] DEV_ZERO = {NUM_DEV{1'b0}};
  localparam logic [NUM_DEV-1:0] DEV_ONE  = {{(NUM_DEV-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]   TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]   TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0]   TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(NUM_DEV - 1);

  // A zero timeout disables the watchdog; the compare value is only
  // meaningful when the watchdog is on.
  localparam logic               TMO_EN   = (TMO_CYCLES != TMO_ZERO);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_CYCLES - TMO_ONE;

  state_t             state_r;
  logic [TMO_W-1:0]   hold_cnt_r;
  logic [NUM_DEV-1:0] lockout_r;

  logic [NUM_DEV-1:0] eligible_s;
  logic [NUM_DEV-1:0] prio_hit_s;
  logic [NUM_DEV-1:0] pset_s;
  logic [ID_W-1:0]    winner_s;
  logic [NUM_DEV-1:0] winner_onehot_s;
  logic [NUM_DEV-1:0] owner_onehot_s;
  logic [NUM_DEV-1:0] sticky_base_s;
  logic               owner_req_s;

  // Round-robin pick: first set bit of pset scanning upward from last+1,
  // wrapping at NUM_DEV. Returns last when pset is empty (caller gates it).
  function automatic logic [ID_W-1:0] pick_winner(
    input logic [NUM_DEV-1:0] pset,
    input logic [ID_W-1:0]    last
  );
    logic [ID_W-1:0] win;
    logic            found;
    int              pos;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_DEV; k++) begin
      pos = int'(last) + k;
      if (pos >= NUM_DEV) begin
        pos = pos - NUM_DEV;
      end else begin
        pos = pos;
      end
      if (!found && pset[pos[ID_W-1:0]]) begin
        win   = pos[ID_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Eligibility, priority-class filtering, winner selection and sticky base.
  always_comb begin
    eligible_s = sl_arb_request & ~lockout_r;
    prio_hit_s = eligible_s & prio_mask;
    if (prio_hit_s != DEV_ZERO) begin
      pset_s = prio_hit_s;
    end else begin
      pset_s = eligible_s;
    end
    winner_s        = pick_winner(pset_s, owner_id);
    winner_onehot_s = DEV_ONE << winner_s;
    owner_onehot_s  = DEV_ONE << owner_id;
    owner_req_s     = sl_arb_request[owner_id];
    // A timeout in the same cycle re-sets its bit on top of this base,
    // so a simultaneous set beats the clear.
    if (tmo_clear) begin
      sticky_base_s = DEV_ZERO;
    end else begin
      sticky_base_s = tmo_sticky;
    end
  end

  // Arbiter FSM with registered grant, owner, busy and watchdog outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      sl_arb_grant <= DEV_ZERO;
      owner_id     <= ID_LAST;
      busy         <= 1'b0;
      tmo_pulse    <= 1'b0;
      tmo_sticky   <= DEV_ZERO;
      lockout_r    <= DEV_ZERO;
      hold_cnt_r   <= TMO_ZERO;
    end else begin
      tmo_pulse  <= 1'b0;
      tmo_sticky <= sticky_base_s;
      // Lockout is released as soon as the device lets go of its request.
      lockout_r  <= lockout_r & sl_arb_request;
      case (state_r)
        IDLE: begin
          if (enable && (eligible_s != DEV_ZERO)) begin
            state_r      <= GRANT;
            sl_arb_grant <= winner_onehot_s;
            owner_id     <= winner_s;
            busy         <= 1'b1;
            hold_cnt_r   <= TMO_ZERO;
          end else begin
            state_r      <= IDLE;
            sl_arb_grant <= DEV_ZERO;
          end
        end
        GRANT: begin
          if (hold_cnt_r != TMO_MAX) begin
            hold_cnt_r <= hold_cnt_r + TMO_ONE;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
          // A request drop takes precedence over a coincident timeout.
          if (!owner_req_s) begin
            state_r      <= RELEASE;
            sl_arb_grant <= DEV_ZERO;
          end else if (TMO_EN && (hold_cnt_r == TMO_LAST)) begin
            state_r      <= RELEASE;
            sl_arb_grant <= DEV_ZERO;
            tmo_pulse    <= 1'b1;
            tmo_sticky   <= sticky_base_s | owner_onehot_s;
            lockout_r    <= (lockout_r & sl_arb_request) | owner_onehot_s;
          end else begin
            state_r      <= GRANT;
          end
        end
        RELEASE: begin
          state_r      <= IDLE;
          sl_arb_grant <= DEV_ZERO;
          busy         <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          sl_arb_grant <= DEV_ZERO;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  ice_sl_bus_arbiter_chk #(
    .NUM_DEV (NUM_DEV)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .grant     (sl_arb_grant),
    .busy      (busy),
    .tmo_pulse (tmo_pulse)
  );

endmodule

// ice_sl_bus_arbiter_chk
//   Structural invariants of the arbiter outputs.
module ice_sl_bus_arbiter_chk #(
  parameter int NUM_DEV = 7
) (
  input logic               clk,
  input logic               reset,
  input logic [NUM_DEV-1:0] grant,
  input logic               busy,
  input logic               tmo_pulse
);

  // At most one owner at a time.
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));

  // A revoke always leaves the bus ungranted.
  a_pulse_idle: assert property (@(posedge clk) disable iff (reset)
    tmo_pulse |-> (grant == {NUM_DEV{1'b0}}));

  // Any active grant is reported as busy.
  a_grant_busy: assert property (@(posedge clk) disable iff (reset)
    (grant != {NUM_DEV{1'b0}}) |-> busy);

endmodule

// File: tb/tb_ice_sl_bus_arbiter.sv
// Bench for ice_sl_bus_arbiter with an 8-cycle watchdog. A cycle model
// pushes the expected output word each clock; it is popped and compared
// against the DUT half a cycle later. Directed checks cover the named
// scenarios with constant expectations.

module tb_ice_sl_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [6:0] prio_mask;
  logic [6:0] req;
  logic       tmo_clear;
  logic [6:0] sl_arb_grant;
  logic [2:0] owner_id;
  logic       busy;
  logic       tmo_pulse;
  logic [6:0] tmo_sticky;

  int n_checks;
  int n_fail;

  // Reference model state.
  logic [6:0]  m_grant;
  int          m_owner;
  logic        m_busy;
  logic        m_pulse;
  logic [6:0]  m_sticky;
  logic [6:0]  m_lock;
  int          m_state;
  int          m_hold;
  logic [31:0] exp_q[$];

  ice_sl_bus_arbiter #(
    .NUM_DEV    (7),
    .ID_W       (3),
    .TMO_W      (20),
    .TMO_CYCLES (20'd8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .prio_mask      (prio_mask),
    .sl_arb_request (req),
    .sl_arb_grant   (sl_arb_grant),
    .owner_id       (owner_id),
    .busy           (busy),
    .tmo_pulse      (tmo_pulse),
    .tmo_sticky     (tmo_sticky),
    .tmo_clear      (tmo_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [6:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < 7; i++) begin
      if (((v >> i) & 7'd1) != 7'd0) idx = i;
    end
    return idx;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sees.
  task automatic model_update();
    logic [6:0] elig;
    logic [6:0] pset;
    int         start;
    int         cand;
    logic       found;
    if (reset) begin
      m_grant = 7'd0; m_owner = 6; m_busy = 1'b0; m_pulse = 1'b0;
      m_sticky = 7'd0; m_lock = 7'd0; m_state = 0; m_hold = 0;
    end else begin
      elig    = req & ~m_lock;
      m_pulse = 1'b0;
      if (tmo_clear) m_sticky = 7'd0;
      m_lock  = m_lock & req;
      case (m_state)
        0: begin
          if (enable && elig != 7'd0) begin
            pset  = ((elig & prio_mask) != 7'd0) ? (elig & prio_mask) : elig;
            start = m_owner;
            found = 1'b0;
            for (int k = 1; k <= 7; k++) begin
              cand = (start + k) % 7;
              if (!found && ((pset >> cand) & 7'd1) != 7'd0) begin
                found   = 1'b1;
                m_owner = cand;
              end
            end
            m_grant = 7'd1 << m_owner;
            m_busy  = 1'b1;
            m_hold  = 0;
            m_state = 1;
          end
        end
        1: begin
          if (((req >> m_owner) & 7'd1) == 7'd0) begin
            m_grant = 7'd0;
            m_state = 2;
          end else if (m_hold == 7) begin
            m_grant  = 7'd0;
            m_state  = 2;
            m_pulse  = 1'b1;
            m_sticky = m_sticky | (7'd1 << m_owner);
            m_lock   = m_lock | (7'd1 << m_owner);
          end else begin
            m_hold = m_hold + 1;
          end
        end
        default: begin
          m_busy  = 1'b0;
          m_state = 0;
        end
      endcase
    end
  endtask

  // One clock: model predicts at the edge, DUT is compared at the falling edge.
  task automatic step();
    logic [31:0] got;
    logic [2:0]  m_own3;
    @(posedge clk);
    model_update();
    m_own3 = 3'(m_owner);
    exp_q.push_back({13'd0, m_grant, m_own3, m_busy, m_pulse, m_sticky});
    @(negedge clk);
    got = {13'd0, sl_arb_grant, owner_id, busy, tmo_pulse, tmo_sticky};
    check_value("scoreboard", got, exp_q.pop_front());
  endtask

  // Step until some grant is visible, bounded.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (sl_arb_grant == 7'd0 && n < 10) begin
      step();
      n++;
    end
    if (sl_arb_grant == 7'd0) check_value(tag, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; enable = 1'b1; prio_mask = 7'd0; req = 7'd0; tmo_clear = 1'b0;
    @(negedge clk);
    do_reset();
    check_value("rst_grant",  32'(sl_arb_grant), 32'd0);
    check_value("rst_owner",  32'(owner_id),     32'd6);
    check_value("rst_busy",   32'(busy),         32'd0);
    check_value("rst_pulse",  32'(tmo_pulse),    32'd0);
    check_value("rst_sticky", 32'(tmo_sticky),   32'd0);

    // Basic grant, release, turnaround, next grant.
    req = 7'b0000101;
    step();
    check_value("t1_first", 32'(sl_arb_grant), 32'h01);
    step(); step();
    req = 7'b0000100;
    step();
    check_value("t1_drop",   32'(sl_arb_grant), 32'h00);
    check_value("t1_rlbusy", 32'(busy),         32'd1);
    step();
    check_value("t1_gap",    32'(sl_arb_grant), 32'h00);
    step();
    check_value("t1_next",   32'(sl_arb_grant), 32'h04);
    check_value("t1_owner",  32'(owner_id),     32'd2);
    req = 7'd0;
    step(); step(); step();

    // Round robin across all requesters with a zero cycle between grants.
    do_reset();
    req = 7'h7F;
    for (int g = 0; g < 8; g++) begin
      wait_grant("t2_wait");
      check_value("t2_order", 32'(onehot_idx(sl_arb_grant)), 32'(g % 7));
      for (int c = 1; c < 4; c++) step();
      req = 7'h7F & ~sl_arb_grant;
      step();
      check_value("t2_gap", 32'(sl_arb_grant), 32'd0);
      req = 7'h7F;
      step();
    end
    req = 7'd0;
    step(); step(); step();

    // Priority class overrides round-robin order.
    do_reset();
    req = 7'h7F;
    step();
    check_value("t3_own0", 32'(sl_arb_grant), 32'h01);
    prio_mask = 7'b0100000;
    req = 7'h7E;
    step();
    req = 7'h7F;
    step();
    step();
    check_value("t3_prio", 32'(sl_arb_grant), 32'h20);
    prio_mask = 7'd0;
    req = 7'd0;
    step(); step(); step();

    // Watchdog revoke, lockout, clear, and clear-vs-set collision.
    do_reset();
    req = 7'b0001000;
    step();
    check_value("t4_grant", 32'(sl_arb_grant), 32'h08);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sl_arb_grant == 7'd0) break;
      cnt++;
    end
    check_value("t4_hold",    32'(cnt),        32'd8);
    check_value("t4_pulse",   32'(tmo_pulse),  32'd1);
    check_value("t4_sticky",  32'(tmo_sticky), 32'h08);
    step();
    check_value("t4_pulse1",  32'(tmo_pulse),  32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_value("t4_locked", 32'(sl_arb_grant), 32'd0);
    end
    tmo_clear = 1'b1;
    step();
    tmo_clear = 1'b0;
    check_value("t4_clear", 32'(tmo_sticky), 32'd0);
    req = 7'd0;
    step();
    req = 7'b0001000;
    step();
    check_value("t4_regrant", 32'(sl_arb_grant), 32'h08);
    for (int i = 0; i < 7; i++) step();
    check_value("t4_still", 32'(sl_arb_grant), 32'h08);
    tmo_clear = 1'b1;
    step();
    tmo_clear = 1'b0;
    check_value("t6_clrset_pulse",  32'(tmo_pulse),  32'd1);
    check_value("t6_clrset_sticky", 32'(tmo_sticky), 32'h08);
    req = 7'd0;
    step(); step(); step();

    // enable=0 lets the owner finish but blocks new grants.
    do_reset();
    req = 7'b0000010;
    step();
    check_value("t5_grant", 32'(sl_arb_grant), 32'h02);
    enable = 1'b0;
    req = 7'b0000110;
    step(); step();
    check_value("t5_keep", 32'(sl_arb_grant), 32'h02);
    req = 7'b0000100;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("t5_blocked", 32'(sl_arb_grant), 32'd0);
    end
    enable = 1'b1;
    step();
    check_value("t5_resume", 32'(sl_arb_grant), 32'h04);

    // Reset in the middle of a grant.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_value("t6_grant", 32'(sl_arb_grant), 32'd0);
    check_value("t6_owner", 32'(owner_id),     32'd6);
    check_value("t6_busy",  32'(busy),         32'd0);
    req = 7'd0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
